// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - two-entry elastic buffer between execute and memory stages
//
// Captures each accepted ALU result with its destination and memory-op fields
// and presents the oldest entry to the memory stage over valid/ready.
// in_ready_o comes straight from a flop, so a memory-stage stall never reaches
// execute timing combinationally. Two combinational lookup ports let
// decode/issue bypass results that are still held here.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o      execute-side handshake
//   in_res_i .. in_store_data_i  entry fields captured on push
//   flush_i                      drops the contents and this cycle's input
//   out_valid_o / out_ready_i    memory-side handshake for the head entry
//   out_res_o .. out_store_data_o head entry fields
//   fwd_rs*_i / fwd_rs*_hit_o / fwd_rs*_data_o  forwarding lookups

module ex_mem_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_res_i,
    input  logic [4:0]      in_rd_i,
    input  logic            in_rd_we_i,
    input  logic [1:0]      in_mem_op_i,
    input  logic [1:0]      in_mem_size_i,
    input  logic [XLEN-1:0] in_store_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_res_o,
    output logic [4:0]      out_rd_o,
    output logic            out_rd_we_o,
    output logic [1:0]      out_mem_op_o,
    output logic [1:0]      out_mem_size_o,
    output logic [XLEN-1:0] out_store_data_o,
    input  logic [4:0]      fwd_rs1_i,
    input  logic [4:0]      fwd_rs2_i,
    output logic            fwd_rs1_hit_o,
    output logic            fwd_rs2_hit_o,
    output logic [XLEN-1:0] fwd_rs1_data_o,
    output logic [XLEN-1:0] fwd_rs2_data_o
);

    localparam logic [1:0] MEM_OP_LOAD = 2'b01;

    // Entry payload; deliberately not reset.
    logic [XLEN-1:0] res_q        [DEPTH];
    logic [4:0]      rd_q         [DEPTH];
    logic            rd_we_q      [DEPTH];
    logic [1:0]      mem_op_q     [DEPTH];
    logic [1:0]      mem_size_q   [DEPTH];
    logic [XLEN-1:0] store_data_q [DEPTH];

    logic       head_q;
    logic       tail_q;
    logic [1:0] count_q;
    logic [1:0] count_next;
    logic       ready_q;

    logic push;
    logic pop;

    assign in_ready_o  = ready_q;
    assign push        = in_valid_i & ready_q & ~flush_i;
    assign out_valid_o = (count_q != 2'd0) & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;
    assign count_next  = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_next;
            // Ready is recomputed from the next count so a pop at full only
            // reopens the input on the following cycle.
            ready_q <= (count_next != 2'd2);
            if (push) begin
                tail_q <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            res_q[tail_q]        <= in_res_i;
            rd_q[tail_q]         <= in_rd_i;
            rd_we_q[tail_q]      <= in_rd_we_i;
            mem_op_q[tail_q]     <= in_mem_op_i;
            mem_size_q[tail_q]   <= in_mem_size_i;
            store_data_q[tail_q] <= in_store_data_i;
        end
    end

    assign out_res_o        = res_q[head_q];
    assign out_rd_o         = rd_q[head_q];
    assign out_rd_we_o      = rd_we_q[head_q];
    assign out_mem_op_o     = mem_op_q[head_q];
    assign out_mem_size_o   = mem_size_q[head_q];
    assign out_store_data_o = store_data_q[head_q];

    // The youngest entry always sits just behind the tail. The other slot
    // (at tail) is occupied only when the buffer is full, and is then older.
    logic young_idx;
    logic old_idx;
    logic young_occ;
    logic old_occ;

    assign young_idx = ~tail_q;
    assign old_idx   = tail_q;
    assign young_occ = (count_q != 2'd0);
    assign old_occ   = (count_q == 2'd2);

    logic [4:0]      fwd_rs   [2];
    logic            fwd_hit  [2];
    logic [XLEN-1:0] fwd_data [2];

    assign fwd_rs[0] = fwd_rs1_i;
    assign fwd_rs[1] = fwd_rs2_i;

    // The youngest matching writer decides. If it is a load, the value is not
    // available yet, so report no hit rather than forwarding an older, stale
    // result; load-use stalls are handled elsewhere.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            if (!flush_i && fwd_rs[p] != 5'd0) begin
                if (young_occ && rd_we_q[young_idx] && rd_q[young_idx] == fwd_rs[p]) begin
                    if (mem_op_q[young_idx] != MEM_OP_LOAD) begin
                        fwd_hit[p]  = 1'b1;
                        fwd_data[p] = res_q[young_idx];
                    end
                end else if (old_occ && rd_we_q[old_idx] && rd_q[old_idx] == fwd_rs[p]) begin
                    if (mem_op_q[old_idx] != MEM_OP_LOAD) begin
                        fwd_hit[p]  = 1'b1;
                        fwd_data[p] = res_q[old_idx];
                    end
                end
            end
        end
    end

    assign fwd_rs1_hit_o  = fwd_hit[0];
    assign fwd_rs2_hit_o  = fwd_hit[1];
    assign fwd_rs1_data_o = fwd_data[0];
    assign fwd_rs2_data_o = fwd_data[1];

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - directed self-checking bench for ex_mem_buffer

module tb_ex_mem_buffer;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_res_i;
    logic [4:0]      in_rd_i;
    logic            in_rd_we_i;
    logic [1:0]      in_mem_op_i;
    logic [1:0]      in_mem_size_i;
    logic [XLEN-1:0] in_store_data_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_res_o;
    logic [4:0]      out_rd_o;
    logic            out_rd_we_o;
    logic [1:0]      out_mem_op_o;
    logic [1:0]      out_mem_size_o;
    logic [XLEN-1:0] out_store_data_o;
    logic [4:0]      fwd_rs1_i;
    logic [4:0]      fwd_rs2_i;
    logic            fwd_rs1_hit_o;
    logic            fwd_rs2_hit_o;
    logic [XLEN-1:0] fwd_rs1_data_o;
    logic [XLEN-1:0] fwd_rs2_data_o;

    int checks   = 0;
    int failures = 0;

    ex_mem_buffer #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_res_i         (in_res_i),
        .in_rd_i          (in_rd_i),
        .in_rd_we_i       (in_rd_we_i),
        .in_mem_op_i      (in_mem_op_i),
        .in_mem_size_i    (in_mem_size_i),
        .in_store_data_i  (in_store_data_i),
        .flush_i          (flush_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_res_o        (out_res_o),
        .out_rd_o         (out_rd_o),
        .out_rd_we_o      (out_rd_we_o),
        .out_mem_op_o     (out_mem_op_o),
        .out_mem_size_o   (out_mem_size_o),
        .out_store_data_o (out_store_data_o),
        .fwd_rs1_i        (fwd_rs1_i),
        .fwd_rs2_i        (fwd_rs2_i),
        .fwd_rs1_hit_o    (fwd_rs1_hit_o),
        .fwd_rs2_hit_o    (fwd_rs2_hit_o),
        .fwd_rs1_data_o   (fwd_rs1_data_o),
        .fwd_rs2_data_o   (fwd_rs2_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge, well away from it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] rd,
                         input logic we, input logic [1:0] op, input logic [1:0] sz,
                         input logic [63:0] sd);
        in_valid_i      = v;
        in_res_i        = res;
        in_rd_i         = rd;
        in_rd_we_i      = we;
        in_mem_op_i     = op;
        in_mem_size_i   = sz;
        in_store_data_i = sd;
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        fwd_rs1_i   = 5'd5;
        fwd_rs2_i   = 5'd0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        step();
        step();
        rst_i = 1'b0;
        #1;

        // Reset / idle
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_hit1", fwd_rs1_hit_o, 1'b0);
        check("rst_hit2", fwd_rs2_hit_o, 1'b0);

        // Single push, popped the next cycle
        out_ready_i = 1'b1;
        drive(1'b1, 64'h1234, 5'd5, 1'b1, 2'b00, 2'b11, 64'h0);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        check("single_valid", out_valid_o, 1'b1);
        check("single_res", out_res_o, 64'h1234);
        check("single_rd", out_rd_o, 5'd5);
        check("single_we", out_rd_we_o, 1'b1);
        check("single_fwd_hit", fwd_rs1_hit_o, 1'b1);
        check("single_fwd_data", fwd_rs1_data_o, 64'h1234);
        step();
        check("single_drained", out_valid_o, 1'b0);
        check("single_ready", in_ready_o, 1'b1);

        // Fill, hold a third push while full, then drain in order
        out_ready_i = 1'b0;
        drive(1'b1, 64'h11, 5'd1, 1'b1, 2'b00, 2'b00, 64'h0);
        step();
        drive(1'b1, 64'h22, 5'd2, 1'b1, 2'b00, 2'b00, 64'h0);
        check("fill_ready_c1", in_ready_o, 1'b1);
        step();
        check("fill_ready_c2", in_ready_o, 1'b0);
        drive(1'b1, 64'h33, 5'd3, 1'b1, 2'b00, 2'b00, 64'h0);
        for (int i = 0; i < 3; i++) begin
            check("full_ready_held", in_ready_o, 1'b0);
            check("full_head_stable", out_res_o, 64'h11);
            step();
        end
        out_ready_i = 1'b1;
        check("drain_a", out_res_o, 64'h11);
        check("drain_ready_same_cycle", in_ready_o, 1'b0);
        step();
        check("drain_b", out_res_o, 64'h22);
        check("drain_ready_after_pop", in_ready_o, 1'b1);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        check("drain_c", out_res_o, 64'h33);
        check("drain_c_rd", out_rd_o, 5'd3);
        check("drain_c_valid", out_valid_o, 1'b1);
        step();
        check("drain_empty", out_valid_o, 1'b0);

        // Forwarding: two matching entries, younger wins
        out_ready_i = 1'b0;
        drive(1'b1, 64'hAA, 5'd7, 1'b1, 2'b00, 2'b00, 64'h0);
        step();
        drive(1'b1, 64'hBB, 5'd7, 1'b1, 2'b00, 2'b00, 64'h0);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        fwd_rs1_i = 5'd7;
        fwd_rs2_i = 5'd8;
        #1;
        check("fwd_young_hit", fwd_rs1_hit_o, 1'b1);
        check("fwd_young_data", fwd_rs1_data_o, 64'hBB);
        check("fwd_miss_hit", fwd_rs2_hit_o, 1'b0);
        check("fwd_miss_data", fwd_rs2_data_o, 64'h0);

        // Flush while full with an input offered
        flush_i = 1'b1;
        drive(1'b1, 64'h99, 5'd7, 1'b1, 2'b00, 2'b00, 64'h0);
        #1;
        check("flush_out_valid", out_valid_o, 1'b0);
        check("flush_fwd_hit", fwd_rs1_hit_o, 1'b0);
        step();
        flush_i = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        #1;
        check("post_flush_ready", in_ready_o, 1'b1);
        check("post_flush_valid", out_valid_o, 1'b0);
        check("post_flush_fwd", fwd_rs1_hit_o, 1'b0);

        // rd=0 never forwards
        drive(1'b1, 64'h44, 5'd0, 1'b1, 2'b00, 2'b00, 64'h0);
        step();
        fwd_rs2_i = 5'd0;
        #1;
        check("fwd_x0_hit", fwd_rs2_hit_o, 1'b0);
        check("fwd_x0_head", out_res_o, 64'h44);

        // Older writer of x9, then a younger load of x9 blocks forwarding
        out_ready_i = 1'b1;
        drive(1'b1, 64'h55, 5'd9, 1'b1, 2'b00, 2'b10, 64'h0);
        step();
        out_ready_i = 1'b0;
        drive(1'b1, 64'h66, 5'd9, 1'b1, 2'b01, 2'b11, 64'h0);
        fwd_rs1_i = 5'd9;
        #1;
        check("fwd_single_hit", fwd_rs1_hit_o, 1'b1);
        check("fwd_single_data", fwd_rs1_data_o, 64'h55);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        check("fwd_load_hit", fwd_rs1_hit_o, 1'b0);
        check("fwd_load_data", fwd_rs1_data_o, 64'h0);
        check("load_head_res", out_res_o, 64'h55);
        out_ready_i = 1'b1;
        step();
        check("load_entry_op", out_mem_op_o, 2'b01);
        check("load_entry_size", out_mem_size_o, 2'b11);
        step();
        check("load_drained", out_valid_o, 1'b0);

        // Steady push+pop at count=1 with pointer wrap; mem_op=11 carried
        drive(1'b1, 64'h100, 5'd10, 1'b1, 2'b11, 2'b11, 64'hDEAD_0000);
        fwd_rs1_i = 5'd10;
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 5'd10, 1'b1, 2'b11, 2'b11, 64'hDEAD_0000 + 64'(i));
            check("pp_valid", out_valid_o, 1'b1);
            check("pp_ready", in_ready_o, 1'b1);
            check("pp_res", out_res_o, 64'h100 + 64'(i - 1));
            check("pp_sd", out_store_data_o, 64'hDEAD_0000 + 64'(i - 1));
            check("pp_op", out_mem_op_o, 2'b11);
            check("pp_fwd_hit", fwd_rs1_hit_o, 1'b1);
            check("pp_fwd_data", fwd_rs1_data_o, 64'h100 + 64'(i - 1));
            step();
        end
        drive(1'b0, 64'h0, 5'd0, 1'b0, 2'b00, 2'b00, 64'h0);
        check("pp_last", out_res_o, 64'h10A);
        check("pp_last_valid", out_valid_o, 1'b1);
        step();
        check("pp_empty", out_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
